// File: rtl/sat_clause_loader_if.sv
// Clause stream into sat_clause_loader: one 3-literal clause per valid/ready handshake.
interface sat_clause_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_clause;
    logic        in_last;

    modport master (output in_valid, output in_clause, output in_last, input in_ready);
    modport slave  (input in_valid, input in_clause, input in_last, output in_ready);
endinterface

// File: rtl/sat_clause_loader.sv
// Buffers one frame of 3-literal clauses, replays it nibble-serially into the tinysat core, then runs it.
// Optional macro LOADER_LIT_CHECK_EN adds a sticky lit_err flag for out-of-range literals.
module sat_clause_loader #(
    parameter int               NUM_BITS         = 6,
    parameter int               LOG2_NUM_CLAUSES = 5,
    parameter logic signed [3:0] PAD_LIT         = 4'sd1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    sat_clause_loader_if.slave        in_bus,
    output logic                      sat_reset,
    output logic                      sat_load,
    output logic [3:0]                sat_data,
    output logic                      sat_run,
    input  logic                      sat_done,
    output logic                      frame_done,
    input  logic                      clear,
    output logic [LOG2_NUM_CLAUSES:0] clause_cnt
`ifdef LOADER_LIT_CHECK_EN
    ,
    output logic                      lit_err
`endif
);

    localparam int CNT_W       = LOG2_NUM_CLAUSES + 2;
    localparam int NUM_CLAUSES = 1 << LOG2_NUM_CLAUSES;
    localparam logic [LOG2_NUM_CLAUSES:0] LAST_SLOT = (LOG2_NUM_CLAUSES + 1)'(NUM_CLAUSES - 1);
    localparam logic [LOG2_NUM_CLAUSES:0] CC_ONE    = (LOG2_NUM_CLAUSES + 1)'(1);
    localparam logic [CNT_W-1:0]          CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_CLR     = 3'd1,
        ST_STREAM  = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                      state_r;
    logic [CNT_W-1:0]            cnt_r;
    logic [11:0]                 buf_r [NUM_CLAUSES];
    logic                        handshake_s;
    logic [LOG2_NUM_CLAUSES:0]   cnt_m1_s;
    logic [LOG2_NUM_CLAUSES-1:0] slot_s;
    logic [11:0]                 clause_s;
    logic [3:0]                  nib_s;

    // Literal is illegal when zero or its magnitude exceeds the variable count.
    function automatic logic lit_bad(input logic [3:0] lit);
        logic [3:0] mag;
        mag     = lit[3] ? (4'd0 - lit) : lit;
        lit_bad = (lit == 4'd0) || ({28'd0, mag} > NUM_BITS);
    endfunction

    assign handshake_s = (state_r == ST_COLLECT) && in_bus.in_valid && in_bus.in_ready;
    assign cnt_m1_s    = clause_cnt - CC_ONE;

    // Select the nibble for the current load counter; unused slots replay the last real clause.
    always_comb begin
        slot_s   = cnt_r[LOG2_NUM_CLAUSES-1:0];
        clause_s = {PAD_LIT, PAD_LIT, PAD_LIT};
        nib_s    = 4'h0;
        if (clause_cnt == '0) begin
            clause_s = {PAD_LIT, PAD_LIT, PAD_LIT};
        end else begin
            if ({1'b0, cnt_r[LOG2_NUM_CLAUSES-1:0]} >= clause_cnt) begin
                slot_s = cnt_m1_s[LOG2_NUM_CLAUSES-1:0];
            end else begin
                slot_s = cnt_r[LOG2_NUM_CLAUSES-1:0];
            end
            clause_s = buf_r[slot_s];
        end
        case (cnt_r[CNT_W-1 -: 2])
            2'd0:    nib_s = 4'h0;
            2'd1:    nib_s = clause_s[3:0];
            2'd2:    nib_s = clause_s[7:4];
            2'd3:    nib_s = clause_s[11:8];
            default: nib_s = 4'h0;
        endcase
    end

    // Clause buffer; contents need no reset since clause_cnt bounds what is read.
    always_ff @(posedge clk) begin
        if (handshake_s) begin
            buf_r[clause_cnt[LOG2_NUM_CLAUSES-1:0]] <= in_bus.in_clause;
        end
    end

    // Frame sequencer: COLLECT -> CLR -> STREAM -> RUN -> DONE, all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_COLLECT;
            cnt_r           <= '0;
            clause_cnt      <= '0;
            in_bus.in_ready <= 1'b1;
            sat_reset       <= 1'b1;
            sat_load        <= 1'b0;
            sat_data        <= 4'h0;
            sat_run         <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    if (handshake_s) begin
                        clause_cnt <= clause_cnt + CC_ONE;
                        if (in_bus.in_last || (clause_cnt == LAST_SLOT)) begin
                            in_bus.in_ready <= 1'b0;
                            cnt_r           <= '0;
                            state_r         <= ST_CLR;
                        end
                    end
                end
                ST_CLR: begin
                    sat_reset <= 1'b0;
                    sat_load  <= 1'b1;
                    sat_data  <= nib_s;
                    cnt_r     <= cnt_r + CNT_ONE;
                    state_r   <= ST_STREAM;
                end
                ST_STREAM: begin
                    // Counter has wrapped once the last group has been emitted.
                    if (cnt_r == '0) begin
                        sat_load <= 1'b0;
                        sat_data <= 4'h0;
                        sat_run  <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        sat_data <= nib_s;
                        cnt_r    <= cnt_r + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (sat_done) begin
                        sat_run    <= 1'b0;
                        frame_done <= 1'b1;
                        state_r    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (clear) begin
                        clause_cnt      <= '0;
                        sat_reset       <= 1'b1;
                        frame_done      <= 1'b0;
                        in_bus.in_ready <= 1'b1;
                        state_r         <= ST_COLLECT;
                    end
                end
                default: begin
                    state_r         <= ST_COLLECT;
                    clause_cnt      <= '0;
                    in_bus.in_ready <= 1'b1;
                    sat_reset       <= 1'b1;
                    sat_load        <= 1'b0;
                    sat_run         <= 1'b0;
                    frame_done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOADER_LIT_CHECK_EN
    // Sticky literal-range error, cleared when a new frame is opened by clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lit_err <= 1'b0;
        end else if ((state_r == ST_DONE) && clear) begin
            lit_err <= 1'b0;
        end else if (handshake_s && (lit_bad(in_bus.in_clause[3:0]) ||
                                     lit_bad(in_bus.in_clause[7:4]) ||
                                     lit_bad(in_bus.in_clause[11:8]))) begin
            lit_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sat_clause_loader.sv
// Directed self-checking bench for sat_clause_loader (also exercises LOADER_LIT_CHECK_EN when defined).
module tb_sat_clause_loader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sat_reset, sat_load, sat_run, sat_done, frame_done, clear;
    logic [3:0] sat_data;
    logic [5:0] clause_cnt;
`ifdef LOADER_LIT_CHECK_EN
    logic       lit_err;
`endif

    sat_clause_loader_if bus ();

    sat_clause_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_bus     (bus),
        .sat_reset  (sat_reset),
        .sat_load   (sat_load),
        .sat_data   (sat_data),
        .sat_run    (sat_run),
        .sat_done   (sat_done),
        .frame_done (frame_done),
        .clear      (clear),
        .clause_cnt (clause_cnt)
`ifdef LOADER_LIT_CHECK_EN
        ,
        .lit_err    (lit_err)
`endif
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] l1 [32];
    logic [3:0] l2 [32];
    logic [3:0] l3 [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic last);
        bus.in_valid  = 1'b1;
        bus.in_clause = {l3[k], l2[k], l1[k]};
        bus.in_last   = last;
        step();
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
    endtask

    // Hand-derived sequence for the {1,-2,3},{-1,2,4} frame.
    function automatic logic [3:0] exp_two(input int i);
        if (i < 32)       return 4'h0;
        else if (i == 32) return 4'h1;
        else if (i < 64)  return 4'hF;
        else if (i == 64) return 4'hE;
        else if (i < 96)  return 4'h2;
        else if (i == 96) return 4'h3;
        else              return 4'h4;
    endfunction

    function automatic logic [3:0] exp_nib(input int i, input int n);
        int s;
        int g;
        g = i / 32;
        s = i % 32;
        if (s >= n) s = n - 1;
        case (g)
            1:       return l1[s];
            2:       return l2[s];
            3:       return l3[s];
            default: return 4'h0;
        endcase
    endfunction

    task automatic check_stream(input int n, input bit hand);
        for (int i = 0; i < 128; i++) begin
            step();
            chk($sformatf("load%0d", i), sat_load, 1);
            chk($sformatf("srst%0d", i), sat_reset, 0);
            chk($sformatf("data%0d", i), sat_data, hand ? exp_two(i) : exp_nib(i, n));
        end
        step();
        chk("load_end", sat_load, 0);
        chk("run_start", sat_run, 1);
    endtask

    task automatic run_and_clear();
        for (int i = 0; i < 9; i++) begin
            clear = (i == 3);
            step();
            chk("run_hold", sat_run, 1);
            chk("fd_in_run", frame_done, 0);
        end
        clear    = 1'b0;
        sat_done = 1'b1;
        step();
        sat_done = 1'b0;
        chk("run_fall", sat_run, 0);
        chk("fd_set", frame_done, 1);
        chk("srst_done", sat_reset, 0);
        step();
        chk("fd_hold", frame_done, 1);
        chk("rdy_done", bus.in_ready, 0);
        clear         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_clause = 12'h111;
        step();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_cnt", clause_cnt, 0);
        chk("clr_rdy", bus.in_ready, 1);
        chk("clr_fd", frame_done, 0);
        chk("clr_srst", sat_reset, 1);
        step();
        chk("clr_nohs", clause_cnt, 0);
    endtask

    initial begin
        reset_n       = 1'b0;
        sat_done      = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_clause = 12'h000;
        bus.in_last   = 1'b0;
        #12;
        chk("rst_rdy", bus.in_ready, 1);
        chk("rst_cnt", clause_cnt, 0);
        chk("rst_srst", sat_reset, 1);
        chk("rst_load", sat_load, 0);
        chk("rst_data", sat_data, 0);
        chk("rst_run", sat_run, 0);
        chk("rst_fd", frame_done, 0);
`ifdef LOADER_LIT_CHECK_EN
        chk("rst_lerr", lit_err, 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Two-clause frame
        l1[0] = 4'h1; l2[0] = 4'hE; l3[0] = 4'h3;
        l1[1] = 4'hF; l2[1] = 4'h2; l3[1] = 4'h4;
        send(0, 1'b0);
        chk("t1_cnt1", clause_cnt, 1);
        chk("t1_rdy1", bus.in_ready, 1);
        send(1, 1'b1);
        chk("t1_cnt2", clause_cnt, 2);
        chk("t1_clr_rdy", bus.in_ready, 0);
        chk("t1_clr_srst", sat_reset, 1);
        chk("t1_clr_load", sat_load, 0);
        check_stream(2, 1'b1);
        run_and_clear();

        // Full 32-clause frame without in_last
        for (int k = 0; k < 32; k++) begin
            l1[k] = 4'((k % 6) + 1);
            l2[k] = 4'(16 - ((k % 5) + 1));
            l3[k] = 4'((k % 4) + 2);
        end
        for (int k = 0; k < 32; k++) send(k, 1'b0);
        chk("t2_cnt", clause_cnt, 32);
        chk("t2_rdy", bus.in_ready, 0);
        bus.in_valid  = 1'b1;
        bus.in_clause = 12'h555;
        check_stream(32, 1'b0);
        bus.in_valid = 1'b0;
        chk("t2_cnt_after", clause_cnt, 32);
        run_and_clear();

        // Single clause: slots 1..31 replay clause 0
        l1[0] = 4'h2; l2[0] = 4'hD; l3[0] = 4'h5;
        send(0, 1'b1);
        chk("t3_cnt", clause_cnt, 1);
        check_stream(1, 1'b0);
        run_and_clear();

`ifdef LOADER_LIT_CHECK_EN
        // Out-of-range literal 7 with six variables
        l1[0] = 4'h1; l2[0] = 4'h1; l3[0] = 4'h7;
        send(0, 1'b1);
        chk("t4_lerr_set", lit_err, 1);
        check_stream(1, 1'b0);
        chk("t4_lerr_run", lit_err, 1);
        run_and_clear();
        chk("t4_lerr_clr", lit_err, 0);
`endif

        // Reset in the middle of STREAM
        l1[0] = 4'h1; l2[0] = 4'hE; l3[0] = 4'h3;
        l1[1] = 4'hF; l2[1] = 4'h2; l3[1] = 4'h4;
        send(0, 1'b0);
        send(1, 1'b1);
        for (int i = 0; i <= 50; i++) step();
        chk("t5_pre_load", sat_load, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_load", sat_load, 0);
        chk("t5_srst", sat_reset, 1);
        chk("t5_rdy", bus.in_ready, 1);
        chk("t5_cnt", clause_cnt, 0);
        step();
        reset_n = 1'b1;
        step();
        l1[0] = 4'h3; l2[0] = 4'hC; l3[0] = 4'h1;
        send(0, 1'b1);
        chk("t5_cnt1", clause_cnt, 1);
        check_stream(1, 1'b0);
        run_and_clear();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
